// File: rtl/pixel_scan_gen.sv
// pixel_scan_gen
//   Raster-order pixel generator feeding the Mandelbrot iteration pipeline.
//   A start pulse in IDLE latches the view window (re_min, im_max, step) and
//   emits one pixel per clock: screen address (pix_x, pix_y) plus complex
//   constant (c_re, c_im). Coordinates are stepped incrementally and wrap
//   modulo 2^COORD_WIDTH.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       frame request, sampled only in IDLE
//   hold        (SCAN_HOLD_EN only) pause emission without losing pixels
//   re_min      real part of the left column
//   im_max      imaginary part of the top row
//   step        per-pixel delta on both axes
//   busy        high while scanning
//   pix_valid   pixel outputs valid this cycle
//   pix_x/pix_y screen address of the pixel
//   c_re/c_im   complex constant of the pixel
//   pix_last    marks pixel (H_RES-1, V_RES-1)
//   frame_done  one-cycle pulse after the final pixel
//
// Build option: define SCAN_HOLD_EN to add the hold input.
//
// state | meaning
// IDLE  | waiting for start, pix_valid=0, busy=0
// SCAN  | one pixel per cycle (or frozen while hold=1)

module pixel_scan_gen #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 9,
  parameter int COORD_WIDTH = 32,
  parameter int FRAC_BITS   = 28
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
`ifdef SCAN_HOLD_EN
  input  logic                   hold,
`endif
  input  logic [COORD_WIDTH-1:0] re_min,
  input  logic [COORD_WIDTH-1:0] im_max,
  input  logic [COORD_WIDTH-1:0] step,
  output logic                   busy,
  output logic                   pix_valid,
  output logic [X_BITS-1:0]      pix_x,
  output logic [Y_BITS-1:0]      pix_y,
  output logic [COORD_WIDTH-1:0] c_re,
  output logic [COORD_WIDTH-1:0] c_im,
  output logic                   pix_last,
  output logic                   frame_done
);

  if (FRAC_BITS >= COORD_WIDTH || (1 << X_BITS) < H_RES || (1 << Y_BITS) < V_RES) begin : g_param_check
    $error("pixel_scan_gen: inconsistent parameters");
  end

  localparam logic [X_BITS-1:0] X_END = X_BITS'(H_RES - 1);
  localparam logic [Y_BITS-1:0] Y_END = Y_BITS'(V_RES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state, nxt_state;

  logic hold_int;
`ifdef SCAN_HOLD_EN
  assign hold_int = hold;
`else
  assign hold_int = 1'b0;
`endif

  logic [COORD_WIDTH-1:0] re_min_q, im_max_q, step_q;
  logic [COORD_WIDTH-1:0] nxt_re_min, nxt_im_max, nxt_step;
  logic [X_BITS-1:0]      nxt_x;
  logic [Y_BITS-1:0]      nxt_y;
  logic [COORD_WIDTH-1:0] nxt_re, nxt_im;
  logic                   nxt_valid, nxt_busy, nxt_last, nxt_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      re_min_q   <= '0;
      im_max_q   <= '0;
      step_q     <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      c_re       <= '0;
      c_im       <= '0;
      pix_valid  <= 1'b0;
      busy       <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      re_min_q   <= nxt_re_min;
      im_max_q   <= nxt_im_max;
      step_q     <= nxt_step;
      pix_x      <= nxt_x;
      pix_y      <= nxt_y;
      c_re       <= nxt_re;
      c_im       <= nxt_im;
      pix_valid  <= nxt_valid;
      busy       <= nxt_busy;
      pix_last   <= nxt_last;
      frame_done <= nxt_done;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_re_min = re_min_q;
    nxt_im_max = im_max_q;
    nxt_step   = step_q;
    nxt_x      = pix_x;
    nxt_y      = pix_y;
    nxt_re     = c_re;
    nxt_im     = c_im;
    nxt_valid  = 1'b0;
    nxt_busy   = 1'b0;
    nxt_last   = 1'b0;
    nxt_done   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          nxt_state  = SCAN;
          nxt_re_min = re_min;
          nxt_im_max = im_max;
          nxt_step   = step;
          nxt_x      = '0;
          nxt_y      = '0;
          nxt_re     = re_min;
          nxt_im     = im_max;
          nxt_valid  = 1'b1;
          nxt_busy   = 1'b1;
          nxt_last   = (X_END == '0) && (Y_END == '0);
        end
      end
      SCAN: begin
        nxt_busy = 1'b1;
        if (hold_int) begin
          // registered pixel was already emitted; freeze it and go invalid
          nxt_last = pix_last;
        end else if (pix_last) begin
          nxt_state = IDLE;
          nxt_busy  = 1'b0;
          nxt_done  = 1'b1;
        end else begin
          nxt_valid = 1'b1;
          if (pix_x != X_END) begin
            nxt_x  = pix_x + 1'b1;
            nxt_re = c_re + step_q;
          end else begin
            nxt_x  = '0;
            nxt_re = re_min_q;
            nxt_y  = pix_y + 1'b1;
            nxt_im = c_im - step_q;
          end
          nxt_last = (nxt_x == X_END) && (nxt_y == Y_END);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Testbench for pixel_scan_gen on a 4x3 screen: table-driven pixel vectors,
// hand-written corner sequences and randomized frames checked against an
// arithmetic model (pixel k -> x=k%H, y=k/H, c = origin +/- index*step).
// Define SCAN_HOLD_EN for both files to exercise the hold input.

module tb_pixel_scan_gen;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;
  localparam int XB   = 10;
  localparam int YB   = 9;
  localparam int CW   = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
`ifdef SCAN_HOLD_EN
  logic          hold;
`endif
  logic [CW-1:0] re_min, im_max, step;
  logic          busy, pix_valid, pix_last, frame_done;
  logic [XB-1:0] pix_x;
  logic [YB-1:0] pix_y;
  logic [CW-1:0] c_re, c_im;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pixel_scan_gen #(
    .H_RES(H), .V_RES(V), .X_BITS(XB), .Y_BITS(YB), .COORD_WIDTH(CW), .FRAC_BITS(28)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
`ifdef SCAN_HOLD_EN
    .hold       (hold),
`endif
    .re_min     (re_min),
    .im_max     (im_max),
    .step       (step),
    .busy       (busy),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .c_re       (c_re),
    .c_im       (c_im),
    .pix_last   (pix_last),
    .frame_done (frame_done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_re(input logic [31:0] re, input logic [31:0] st, input int k);
    logic [31:0] col;
    col = 32'(k % H);
    return re + col * st;
  endfunction

  function automatic logic [31:0] model_im(input logic [31:0] im, input logic [31:0] st, input int k);
    logic [31:0] row;
    row = 32'(k / H);
    return im - row * st;
  endfunction

  task automatic check_pixel(input string tag, input int k, input logic [31:0] re,
                             input logic [31:0] im, input logic [31:0] st);
    chk($sformatf("%s k%0d valid", tag, k), 32'(pix_valid), 32'd1);
    chk($sformatf("%s k%0d busy", tag, k), 32'(busy), 32'd1);
    chk($sformatf("%s k%0d x", tag, k), 32'(pix_x), 32'(k % H));
    chk($sformatf("%s k%0d y", tag, k), 32'(pix_y), 32'(k / H));
    chk($sformatf("%s k%0d c_re", tag, k), c_re, model_re(re, st, k));
    chk($sformatf("%s k%0d c_im", tag, k), c_im, model_im(im, st, k));
    chk($sformatf("%s k%0d last", tag, k), 32'(pix_last), 32'(k == NPIX - 1));
    chk($sformatf("%s k%0d done", tag, k), 32'(frame_done), 32'd0);
  endtask

  // Entered at a negedge with the DUT idle (or in its frame_done cycle).
  // mode: 0 clean, 1 random input noise, 2 start with re_min=0 at pixel 6,
  //       3 hold for 3 cycles after pixel 5, 4 keep start high.
  task automatic check_frame(input string tag, input logic [31:0] re, input logic [31:0] im,
                             input logic [31:0] st, input int mode);
    re_min = re; im_max = im; step = st; start = 1'b1;
    @(negedge clock);
    if (mode != 4) start = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      check_pixel(tag, k, re, im, st);
      if (mode == 1) begin
        start  = 1'($urandom_range(0, 1));
        re_min = $urandom; im_max = $urandom; step = $urandom;
      end
      if (mode == 2 && k == 6) begin start = 1'b1; re_min = '0; end
      if (mode == 2 && k == 7) start = 1'b0;
`ifdef SCAN_HOLD_EN
      if (mode == 3 && k == 5) begin
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
          @(negedge clock);
          chk($sformatf("%s hold%0d valid", tag, h), 32'(pix_valid), 32'd0);
          chk($sformatf("%s hold%0d busy", tag, h), 32'(busy), 32'd1);
          chk($sformatf("%s hold%0d x", tag, h), 32'(pix_x), 32'd1);
        end
        hold = 1'b0;
      end
`endif
      @(negedge clock);
    end
    if (mode != 4) start = 1'b0;
    chk($sformatf("%s done pulse", tag), 32'(frame_done), 32'd1);
    chk($sformatf("%s done valid", tag), 32'(pix_valid), 32'd0);
    chk($sformatf("%s done busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s done last", tag), 32'(pix_last), 32'd0);
    if (mode != 4) begin
      @(negedge clock);
      chk($sformatf("%s idle done", tag), 32'(frame_done), 32'd0);
      chk($sformatf("%s idle valid", tag), 32'(pix_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [31:0] st;
    int          k;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] cre;
    logic [31:0] cim;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'hE0000000, 32'h10000000, 32'h04000000, 0, 0, 0, 32'hE0000000, 32'h10000000, 0};
    vecs[1] = '{32'hE0000000, 32'h10000000, 32'h04000000, 3, 3, 0, 32'hEC000000, 32'h10000000, 0};
    vecs[2] = '{32'hE0000000, 32'h10000000, 32'h04000000, 8, 0, 2, 32'hE0000000, 32'h08000000, 0};
    vecs[3] = '{32'hE0000000, 32'h10000000, 32'h04000000, 11, 3, 2, 32'hEC000000, 32'h08000000, 1};
    vecs[4] = '{32'h7FFFFFFE, 32'h00000000, 32'h00000001, 0, 0, 0, 32'h7FFFFFFE, 32'h00000000, 0};
    vecs[5] = '{32'h7FFFFFFE, 32'h00000000, 32'h00000001, 1, 1, 0, 32'h7FFFFFFF, 32'h00000000, 0};
    vecs[6] = '{32'h7FFFFFFE, 32'h00000000, 32'h00000001, 2, 2, 0, 32'h80000000, 32'h00000000, 0};
    vecs[7] = '{32'h7FFFFFFE, 32'h00000000, 32'h00000001, 3, 3, 0, 32'h80000001, 32'h00000000, 0};
    vecs[8] = '{32'h7FFFFFFE, 32'h00000000, 32'h00000001, 4, 0, 1, 32'h7FFFFFFE, 32'hFFFFFFFF, 0};

    reset = 1'b1; start = 1'b0;
    re_min = 32'h12345678; im_max = 32'h9ABCDEF0; step = 32'h11111111;
`ifdef SCAN_HOLD_EN
    hold = 1'b0;
`endif
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    chk("reset valid", 32'(pix_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset x", 32'(pix_x), 32'd0);
    chk("reset c_re", c_re, 32'd0);
    chk("reset done", 32'(frame_done), 32'd0);
    start = 1'b0; reset = 1'b0;
    @(negedge clock);
    chk("post reset idle", 32'(pix_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      re_min = vecs[i].re; im_max = vecs[i].im; step = vecs[i].st; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (vecs[i].k) @(negedge clock);
      chk($sformatf("vec%0d valid", i), 32'(pix_valid), 32'd1);
      chk($sformatf("vec%0d x", i), 32'(pix_x), vecs[i].x);
      chk($sformatf("vec%0d y", i), 32'(pix_y), vecs[i].y);
      chk($sformatf("vec%0d c_re", i), c_re, vecs[i].cre);
      chk($sformatf("vec%0d c_im", i), c_im, vecs[i].cim);
      chk($sformatf("vec%0d last", i), 32'(pix_last), vecs[i].last);
      repeat (NPIX - vecs[i].k) @(negedge clock);
      chk($sformatf("vec%0d done", i), 32'(frame_done), 32'd1);
      @(negedge clock);
    end

    check_frame("basic", 32'hE0000000, 32'h10000000, 32'h04000000, 0);
    check_frame("midstart", 32'hE0000000, 32'h10000000, 32'h04000000, 2);

    check_frame("b2b0", 32'hE0000000, 32'h10000000, 32'h04000000, 4);
    check_frame("b2b1", 32'h7FFFFFFE, 32'h00000005, 32'h00000001, 4);
    start = 1'b0;
    @(negedge clock);
    chk("b2b end valid", 32'(pix_valid), 32'd0);
    chk("b2b end done", 32'(frame_done), 32'd0);

    re_min = 32'hE0000000; im_max = 32'h10000000; step = 32'h04000000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst mid x", 32'(pix_x), 32'd1);
    chk("rst mid y", 32'(pix_y), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst mid valid", 32'(pix_valid), 32'd0);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid x0", 32'(pix_x), 32'd0);
    chk("rst mid y0", 32'(pix_y), 32'd0);
    chk("rst mid c_re", c_re, 32'd0);
    chk("rst mid c_im", c_im, 32'd0);
    chk("rst mid last", 32'(pix_last), 32'd0);
    chk("rst mid done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst after done", 32'(frame_done), 32'd0);
    chk("rst after valid", 32'(pix_valid), 32'd0);
    check_frame("after rst", 32'hE0000000, 32'h10000000, 32'h04000000, 0);

`ifdef SCAN_HOLD_EN
    check_frame("hold", 32'hE0000000, 32'h10000000, 32'h04000000, 3);
`endif

    for (int r = 0; r < 6; r++)
      check_frame($sformatf("rnd%0d", r), $urandom, $urandom, $urandom, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
